// File: rtl/gups_pkg.sv
// Shared types and constants for the GUPS read-modify-write engine.
package gups_pkg;

  localparam int          LFSR_W     = 16;
  localparam logic [15:0] LFSR_TAPS  = 16'hB400;
  localparam logic [15:0] LFSR_RESET = 16'h0001;

  localparam logic MODE_INC = 1'b0;
  localparam logic MODE_XOR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GEN,
    ST_RD_REQ,
    ST_MODIFY,
    ST_WR_REQ,
    ST_DONE
  } state_t;

  // Galois right-shift step; also used combinationally to look one step ahead
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : '0);
  endfunction

endpackage

// File: rtl/gups_lfsr.sv
// One 16-bit Galois LFSR lane; a zero seed is forced to the reset value so
// the register can never lock up at all-zeros.
module gups_lfsr
  import gups_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [LFSR_W-1:0] seed,
  input  logic              step,
  output logic [LFSR_W-1:0] value
);

  // load has priority over step; both only happen from the engine FSM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      value <= LFSR_RESET;
    else if (load) value <= (seed == '0) ? LFSR_RESET : seed;
    else if (step) value <= lfsr_next(value);
  end

endmodule

// File: rtl/gups_rmw_engine.sv
// GUPS update engine: random address generation from concatenated LFSRs,
// then a strictly serialised read / modify / write over a req/wr/rdy port.
module gups_rmw_engine
  import gups_pkg::*;
#(
  parameter int ADDR_W   = 64,
  parameter int DATA_W   = 64,
  parameter int NUM_LFSR = 4,
  parameter int CNT_W    = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       mode,
  input  logic [LFSR_W*NUM_LFSR-1:0] seed,
  input  logic [ADDR_W-1:0]          range,
  input  logic [CNT_W-1:0]           num_updates,
  output logic [ADDR_W-1:0]          addr,
  input  logic [DATA_W-1:0]          din,
  output logic [DATA_W-1:0]          dout,
  output logic                       req,
  output logic                       wr,
  input  logic                       rdy,
  output logic                       busy,
  output logic                       done,
  output logic [CNT_W-1:0]           upd_count
);

  localparam int RND_W = NUM_LFSR * LFSR_W;
  localparam int AD_W  = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int EXT_W = (RND_W > AD_W) ? RND_W : AD_W;

  state_t state, nxt;

  logic [NUM_LFSR-1:0][LFSR_W-1:0] lfsr_q, lfsr_nx;
  logic                            lfsr_load, lfsr_step;
  logic [EXT_W-1:0]                rnd_ext, rnd_nx_ext;

  logic              mode_q;
  logic [ADDR_W-1:0] range_q;
  logic [CNT_W-1:0]  num_q;
  logic [DATA_W-1:0] rdata_q;
  logic              accept, last_upd;

  assign accept    = (state == ST_IDLE) && start;
  assign last_upd  = (upd_count + CNT_W'(1)) == num_q;
  assign lfsr_load = accept;
  assign lfsr_step = (state == ST_GEN);

  genvar g;
  generate
    for (g = 0; g < NUM_LFSR; g++) begin : g_lfsr
      gups_lfsr u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .load  (lfsr_load),
        .seed  (seed[g*LFSR_W +: LFSR_W]),
        .step  (lfsr_step),
        .value (lfsr_q[g])
      );
      assign lfsr_nx[g] = lfsr_next(lfsr_q[g]);
    end
  endgenerate

  // lane 0 is the least significant slice; widen so either port width can slice it
  assign rnd_ext    = EXT_W'(lfsr_q);
  assign rnd_nx_ext = EXT_W'(lfsr_nx);

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= nxt;
  end

  // next-state logic; rdy only matters in the two request states
  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE:   if (start) nxt = (num_updates == '0) ? ST_DONE : ST_GEN;
      ST_GEN:    nxt = ST_RD_REQ;
      ST_RD_REQ: if (rdy) nxt = ST_MODIFY;
      ST_MODIFY: nxt = ST_WR_REQ;
      ST_WR_REQ: if (rdy) nxt = last_upd ? ST_DONE : ST_GEN;
      ST_DONE:   nxt = ST_IDLE;
      default:   nxt = ST_IDLE;
    endcase
  end

  // handshake outputs decode straight from state, so reset drops req at once
  always_comb begin
    req  = 1'b0;
    wr   = 1'b0;
    busy = 1'b0;
    case (state)
      ST_GEN, ST_MODIFY: busy = 1'b1;
      ST_RD_REQ: begin req = 1'b1; busy = 1'b1; end
      ST_WR_REQ: begin req = 1'b1; wr = 1'b1; busy = 1'b1; end
      default: ;
    endcase
  end

  // datapath: run configuration, address/data registers, counter and done flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q    <= MODE_INC;
      range_q   <= '0;
      num_q     <= '0;
      rdata_q   <= '0;
      addr      <= '0;
      dout      <= '0;
      upd_count <= '0;
      done      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          mode_q    <= mode;
          range_q   <= range;
          num_q     <= num_updates;
          upd_count <= '0;
          done      <= 1'b0;
        end
        ST_GEN:    addr <= rnd_nx_ext[ADDR_W-1:0] & range_q;
        ST_RD_REQ: if (rdy) rdata_q <= din;
        ST_MODIFY: dout <= (mode_q == MODE_XOR) ? (rdata_q ^ rnd_ext[DATA_W-1:0])
                                                : (rdata_q + DATA_W'(1));
        ST_WR_REQ: if (rdy) upd_count <= upd_count + CNT_W'(1);
        ST_DONE:   done <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gups_rmw_engine.sv
// Directed + scoreboard bench for gups_rmw_engine with a randomly delayed memory.
module tb_gups_rmw_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic [63:0] seed = '0;
  logic [63:0] rng = '0;
  logic [31:0] num = '0;
  logic [63:0] addr, dout;
  logic [63:0] din = '0;
  logic        req, wr, busy, done;
  logic        rdy = 1'b0;
  logic [31:0] upd_count;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        w;
    logic [63:0] a;
    logic [63:0] d;
  } exp_t;

  exp_t        sbq[$];
  logic [63:0] mem  [8192];
  logic [63:0] refm [8192];
  int          max_dly = 0;
  bit          stall_wr = 1'b0;

  localparam logic [63:0] SEED1 = 64'h0001_0001_0001_0001;

  gups_rmw_engine #(.ADDR_W(64), .DATA_W(64), .NUM_LFSR(4), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .seed(seed), .range(rng),
    .num_updates(num), .addr(addr), .din(din), .dout(dout), .req(req), .wr(wr),
    .rdy(rdy), .busy(busy), .done(done), .upd_count(upd_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] lstep(input logic [15:0] s);
    logic [15:0] n;
    n = {1'b0, s[15:1]};
    if (s[0]) n = n ^ 16'hB400;
    return n;
  endfunction

  // reference replay: pushes one read and one write expectation per update
  task automatic model_run(input logic [63:0] sd, input logic [63:0] msk, input int n,
                           input logic md);
    logic [15:0] l[4];
    logic [63:0] rnd, a, nv;
    for (int i = 0; i < 4; i++) begin
      l[i] = sd[16*i +: 16];
      if (l[i] == 16'h0) l[i] = 16'h0001;
    end
    for (int u = 0; u < n; u++) begin
      for (int i = 0; i < 4; i++) l[i] = lstep(l[i]);
      rnd = {l[3], l[2], l[1], l[0]};
      a   = rnd & msk;
      nv  = md ? (refm[a[12:0]] ^ rnd) : (refm[a[12:0]] + 64'd1);
      refm[a[12:0]] = nv;
      sbq.push_back('{w: 1'b0, a: a, d: 64'h0});
      sbq.push_back('{w: 1'b1, a: a, d: nv});
    end
  endtask

  task automatic init_mem();
    for (int i = 0; i < 8192; i++) begin
      mem[i]  = 64'(i) * 64'h9E37_79B9_7F4A_7C15;
      refm[i] = mem[i];
    end
  endtask

  task automatic push_pair(input logic [63:0] a, input logic [63:0] d);
    sbq.push_back('{w: 1'b0, a: a, d: 64'h0});
    sbq.push_back('{w: 1'b1, a: a, d: d});
  endtask

  task automatic run_start(input logic [63:0] sd, input logic [63:0] rg, input logic [31:0] n,
                           input logic md);
    @(negedge clk);
    seed = sd; rng = rg; num = n; mode = md; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int k = 0;
    while (!done && k < limit) begin
      @(negedge clk);
      k++;
    end
    chk("done_reached", 64'(done), 64'd1);
  endtask

  // memory responder: checks each request against the scoreboard, then strobes rdy
  initial begin : mem_resp
    exp_t        e;
    logic [63:0] a0, d0;
    int          dly;
    forever begin
      @(negedge clk);
      rdy = 1'b0;
      if (rst && req) begin
        a0 = addr;
        d0 = dout;
        chk("sb_has_entry", 64'(sbq.size() != 0), 64'd1);
        if (sbq.size() != 0) begin
          e = sbq.pop_front();
          chk("req_kind", 64'(wr), 64'(e.w));
          chk("req_addr", a0, e.a);
          if (wr) chk("wr_data", d0, e.d);
        end
        if (wr && stall_wr) begin
          for (int k = 0; k < 500 && req; k++) @(negedge clk);
        end else begin
          dly = $urandom_range(0, max_dly);
          for (int k = 0; k < dly; k++) begin
            @(negedge clk);
            chk("req_held", 64'(req), 64'd1);
            chk("addr_held", addr, a0);
            if (wr) chk("dout_held", dout, d0);
          end
          if (wr) mem[a0[12:0]] = dout;
          else    din = mem[a0[12:0]];
          rdy = 1'b1;
        end
      end
    end
  end

  initial begin : main
    logic [63:0] sd;
    int          mism;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_req", 64'(req), 64'd0);
    chk("rst_wr", 64'(wr), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_addr", addr, 64'd0);
    chk("rst_dout", dout, 64'd0);
    chk("rst_cnt", 64'(upd_count), 64'd0);
    rst = 1'b1;

    // basic single increment
    init_mem();
    mem[13'h1400] = 64'd5;
    push_pair(64'h1400, 64'd6);
    run_start(SEED1, 64'h1FFF, 32'd1, 1'b0);
    chk("basic_busy", 64'(busy), 64'd1);
    wait_done(100);
    chk("basic_cnt", 64'(upd_count), 64'd1);
    chk("basic_idle", 64'(busy), 64'd0);
    chk("basic_sb", 64'(sbq.size()), 64'd0);

    // XOR mode against all-ones
    mem[13'h1400] = 64'hFFFF_FFFF_FFFF_FFFF;
    push_pair(64'h1400, 64'h4BFF_4BFF_4BFF_4BFF);
    run_start(SEED1, 64'h1FFF, 32'd1, 1'b1);
    wait_done(100);
    chk("xor_cnt", 64'(upd_count), 64'd1);

    // increment wraps to zero
    mem[13'h1400] = 64'hFFFF_FFFF_FFFF_FFFF;
    push_pair(64'h1400, 64'h0);
    run_start(SEED1, 64'h1FFF, 32'd1, 1'b0);
    wait_done(100);
    chk("wrap_sb", 64'(sbq.size()), 64'd0);

    // zero seed behaves like 16'h0001
    mem[13'h1400] = 64'd7;
    push_pair(64'h1400, 64'd8);
    run_start(64'h0, 64'h1FFF, 32'd1, 1'b0);
    wait_done(100);
    chk("zseed_sb", 64'(sbq.size()), 64'd0);

    // num_updates = 0: done two cycles after start, no request
    run_start(SEED1, 64'h1FFF, 32'd0, 1'b0);
    chk("zero_done_early", 64'(done), 64'd0);
    chk("zero_req", 64'(req), 64'd0);
    @(negedge clk);
    chk("zero_done", 64'(done), 64'd1);
    chk("zero_req2", 64'(req), 64'd0);
    chk("zero_cnt", 64'(upd_count), 64'd0);

    // start pulsed mid-run is ignored
    init_mem();
    max_dly = 2;
    model_run(64'h1234_5678_9ABC_DEF0, 64'h1FFF, 3, 1'b0);
    run_start(64'h1234_5678_9ABC_DEF0, 64'h1FFF, 32'd3, 1'b0);
    repeat (4) @(negedge clk);
    chk("mid_busy", 64'(busy), 64'd1);
    seed = 64'hDEAD_BEEF_0BAD_F00D; num = 32'd1; mode = 1'b1; rng = 64'hFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(500);
    chk("mid_cnt", 64'(upd_count), 64'd3);
    chk("mid_sb", 64'(sbq.size()), 64'd0);

    // long randomised run in XOR mode
    init_mem();
    max_dly = 5;
    sd = {16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)};
    model_run(sd, 64'h1FFF, 1000, 1'b1);
    run_start(sd, 64'h1FFF, 32'd1000, 1'b1);
    wait_done(30000);
    chk("long_cnt", 64'(upd_count), 64'd1000);
    chk("long_sb", 64'(sbq.size()), 64'd0);
    mism = 0;
    for (int i = 0; i < 8192; i++) if (mem[i] !== refm[i]) mism++;
    chk("long_replay", 64'(mism), 64'd0);

    // reset abort while a write is outstanding
    max_dly = 0;
    stall_wr = 1'b1;
    sbq.delete();
    mem[13'h1400] = 64'd5;
    push_pair(64'h1400, 64'd6);
    run_start(SEED1, 64'h1FFF, 32'd1, 1'b0);
    for (int k = 0; k < 50 && !(req && wr); k++) @(negedge clk);
    chk("abort_in_wr", 64'(req && wr), 64'd1);
    #2 rst = 1'b0;
    #1;
    chk("abort_req", 64'(req), 64'd0);
    chk("abort_wr", 64'(wr), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    stall_wr = 1'b0;
    @(negedge clk);
    chk("abort_mem", mem[13'h1400], 64'd5);
    push_pair(64'h1400, 64'd6);
    run_start(SEED1, 64'h1FFF, 32'd1, 1'b0);
    wait_done(100);
    chk("abort_cnt", 64'(upd_count), 64'd1);
    chk("abort_sb", 64'(sbq.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
